// File: rtl/hex_score_controller_if.sv
// Score handshake bundle between the score counter and the HEX controller.
// Ports: score_valid/score from the producer, score_ready back from the controller.
// Producer holds score_valid and score stable until score_ready is seen at a clock edge.
interface hex_score_controller_if;
   logic        score_valid;
   logic [19:0] score;
   logic        score_ready;

   modport master (output score_valid, output score, input score_ready);
   modport slave  (input score_valid, input score, output score_ready);
endinterface

// File: rtl/hex_score_controller.sv
// Converts a binary score (clamped to 999999) to BCD, then scans one shared 7-seg decoder into HEX0..HEX5.
// Latency: accept at E0, 20 double-dabble edges, HEX0..HEX5 written E21..E26, done pulses after E26.
// Backpressure: score_ready is high only in IDLE; offers made while busy are simply not taken.
// Ports: clock, resetn (async, active-low); sif (score_valid/score/score_ready);
//        busy, done (one-cycle pulse), HEX0..HEX5 (registered, active-low, bit0=a .. bit6=g).
module hex_score_controller #(
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                         clock,
   input  logic                         resetn,
   hex_score_controller_if.slave        sif,
   output logic                         busy,
   output logic                         done,
   output logic [6:0]                   HEX0,
   output logic [6:0]                   HEX1,
   output logic [6:0]                   HEX2,
   output logic [6:0]                   HEX3,
   output logic [6:0]                   HEX4,
   output logic [6:0]                   HEX5
);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SCAN} state_t;

   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam logic [6:0]  SEG_ZERO  = 7'h40;
   localparam logic [6:0]  HEX_RST   = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
   localparam logic [19:0] SCORE_MAX = 20'd999999;

   state_t           state_q, state_d;
   logic [19:0]      shift_q, shift_d;
   logic [23:0]      bcd_q, bcd_d;
   logic [4:0]       iter_q, iter_d;
   logic [2:0]       dig_q, dig_d;
   logic             done_q, done_d;
   logic [5:0][6:0]  hex_q, hex_d;

   logic [23:0]      bcd_adj;
   logic [3:0]       cur_nib;
   logic [7:0]       zero_above;
   logic             blank_cur;
   logic [6:0]       seg_cur;

   // Shared decoder; codes 10-15 cannot come out of a valid conversion, show blank if they do.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction applied to every nibble before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   // zero_above[k]: nibbles k..5 are all zero. Bits 7:6 pad the index range of dig_q.
   always_comb begin
      zero_above      = 8'b0;
      zero_above[5]   = (bcd_q[23:20] == 4'd0);
      for (int k = 4; k >= 0; k--)
         zero_above[k] = zero_above[k+1] & (bcd_q[k*4 +: 4] == 4'd0);
   end

   assign cur_nib   = bcd_q[{dig_q, 2'b00} +: 4];
   assign blank_cur = BLANK_LEADING && (dig_q != 3'd0) && zero_above[dig_q];
   assign seg_cur   = blank_cur ? SEG_BLANK : seg7(cur_nib);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      hex_d   = hex_q;
      case (state_q)
         S_IDLE: begin
            if (sif.score_valid) begin
               shift_d = (sif.score > SCORE_MAX) ? SCORE_MAX : sif.score;
               bcd_d   = 24'd0;
               iter_d  = 5'd0;
               state_d = S_CONVERT;
            end
         end
         S_CONVERT: begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            iter_d = iter_q + 5'd1;
            if (iter_q == 5'd19) begin
               state_d = S_SCAN;
               dig_d   = 3'd0;
            end
         end
         S_SCAN: begin
            for (int k = 0; k < 6; k++) begin
               if (dig_q == 3'(k))
                  hex_d[k] = seg_cur;
            end
            dig_d = dig_q + 3'd1;
            if (dig_q == 3'd5) begin
               state_d = S_IDLE;
               dig_d   = 3'd0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         shift_q <= 20'd0;
         bcd_q   <= 24'd0;
         iter_q  <= 5'd0;
         dig_q   <= 3'd0;
         done_q  <= 1'b0;
         hex_q   <= {HEX_RST, HEX_RST, HEX_RST, HEX_RST, HEX_RST, SEG_ZERO};
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
         dig_q   <= dig_d;
         done_q  <= done_d;
         hex_q   <= hex_d;
      end
   end

   // Pure decodes of the state register: no path from score_valid.
   assign sif.score_ready = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign done            = done_q;
   assign HEX0 = hex_q[0];
   assign HEX1 = hex_q[1];
   assign HEX2 = hex_q[2];
   assign HEX3 = hex_q[3];
   assign HEX4 = hex_q[4];
   assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_score_controller.sv
// Bench for hex_score_controller: two instances (leading blanking on / off) driven in lockstep.
// Table of scores with hand-computed segment codes, plus reset, held-valid and scan-order sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_hex_score_controller;

   logic clock;
   logic resetn;
   logic busy1, done1, busy0, done0;
   logic [6:0] hx1 [6];
   logic [6:0] hx0 [6];
   int n_cmp = 0;
   int n_bad = 0;

   hex_score_controller_if if1 ();
   hex_score_controller_if if0 ();

   hex_score_controller #(.BLANK_LEADING(1'b1)) dut1 (
      .clock(clock), .resetn(resetn), .sif(if1.slave), .busy(busy1), .done(done1),
      .HEX0(hx1[0]), .HEX1(hx1[1]), .HEX2(hx1[2]), .HEX3(hx1[3]), .HEX4(hx1[4]), .HEX5(hx1[5]));

   hex_score_controller #(.BLANK_LEADING(1'b0)) dut0 (
      .clock(clock), .resetn(resetn), .sif(if0.slave), .busy(busy0), .done(done0),
      .HEX0(hx0[0]), .HEX1(hx0[1]), .HEX2(hx0[2]), .HEX3(hx0[3]), .HEX4(hx0[4]), .HEX5(hx0[5]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [19:0] score;
      logic [41:0] exp_bl1;   // {HEX5,...,HEX0}
      logic [41:0] exp_bl0;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [19:0] s);
      if1.score_valid = v;
      if0.score_valid = v;
      if1.score = s;
      if0.score = s;
   endtask

   task automatic chk_hex(input string tag, input logic [41:0] e1, input logic [41:0] e0);
      logic [41:0] t1;
      logic [41:0] t0;
      t1 = e1;
      t0 = e0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("%s_bl1_hex%0d", tag, k), {25'd0, hx1[k]}, {25'd0, t1[k*7 +: 7]});
         chk($sformatf("%s_bl0_hex%0d", tag, k), {25'd0, hx0[k]}, {25'd0, t0[k*7 +: 7]});
      end
   endtask

   // Offer a score while idle, then wait (bounded) for done; done must appear 26 edges after E0.
   task automatic send(input logic [19:0] s);
      int lat;
      chk("ready_before_send", {31'd0, if1.score_ready}, 32'd1);
      drive(1'b1, s);
      step();                       // E0
      drive(1'b0, 20'd0);
      chk("busy_after_accept", {31'd0, busy1}, 32'd1);
      chk("ready_after_accept", {31'd0, if1.score_ready}, 32'd0);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (done1) begin
            lat = n;
            break;
         end
      end
      chk("done_latency", lat, 26);
      chk("done_bl0", {31'd0, done0}, 32'd1);
      chk("ready_with_done", {31'd0, if1.score_ready}, 32'd1);
      step();
      chk("done_one_cycle", {31'd0, done1}, 32'd0);
      chk("busy_idle", {31'd0, busy1}, 32'd0);
   endtask

   initial begin
      int dn;
      int d_first;
      int d_second;
      logic [41:0] e654321;
      logic [41:0] all_nine;

      vecs[0] = '{20'd0,       {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}};
      vecs[1] = '{20'd123456,  {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}};
      vecs[2] = '{20'd1048575, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}};
      vecs[3] = '{20'd1000,    {7'h7F,7'h7F,7'h79,7'h40,7'h40,7'h40}, {7'h40,7'h40,7'h79,7'h40,7'h40,7'h40}};
      vecs[4] = '{20'd100005,  {7'h79,7'h40,7'h40,7'h40,7'h40,7'h12}, {7'h79,7'h40,7'h40,7'h40,7'h40,7'h12}};
      vecs[5] = '{20'd90,      {7'h7F,7'h7F,7'h7F,7'h7F,7'h10,7'h40}, {7'h40,7'h40,7'h40,7'h40,7'h10,7'h40}};
      vecs[6] = '{20'd1000000, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}};
      vecs[7] = '{20'd7,       {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h78}, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h78}};
      e654321  = {7'h02,7'h12,7'h19,7'h30,7'h24,7'h79};
      all_nine = {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10};

      // Reset values, checked while reset is held.
      resetn = 1'b1;
      drive(1'b0, 20'd0);
      #2 resetn = 1'b0;
      #1;
      chk_hex("reset", vecs[0].exp_bl1, vecs[0].exp_bl0);
      chk("reset_ready", {31'd0, if1.score_ready}, 32'd1);
      chk("reset_busy", {31'd0, busy1}, 32'd0);
      chk("reset_done", {31'd0, done1}, 32'd0);
      #20 resetn = 1'b1;
      step();

      // Table-driven conversions.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].score);
         chk_hex($sformatf("vec%0d", i), vecs[i].exp_bl1, vecs[i].exp_bl0);
      end

      // Asynchronous reset in the middle of CONVERT.
      send(20'd123456);
      drive(1'b1, 20'd999999);
      step();
      drive(1'b0, 20'd0);
      for (int n = 0; n < 5; n++) step();
      chk("midconv_busy_before", {31'd0, busy1}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk_hex("midconv_reset", vecs[0].exp_bl1, vecs[0].exp_bl0);
      chk("midconv_ready", {31'd0, if1.score_ready}, 32'd1);
      chk("midconv_busy", {31'd0, busy1}, 32'd0);
      chk("midconv_done", {31'd0, done1}, 32'd0);
      #3 resetn = 1'b1;
      step();
      chk("post_reset_idle", {31'd0, if1.score_ready}, 32'd1);

      // score_valid held: 7 then 8 offered during busy; second taken only at E27.
      dn = 0;
      d_first = 0;
      d_second = 0;
      drive(1'b1, 20'd7);
      step();                       // E0
      drive(1'b1, 20'd8);
      for (int n = 1; n <= 53; n++) begin
         step();
         if (done1) begin
            dn++;
            if (dn == 1) d_first = n;
            else d_second = n;
         end
         if (n == 26) chk("hold_hex0_first", {25'd0, hx1[0]}, 32'h78);
         if (n == 26) chk("hold_ready_e26", {31'd0, if1.score_ready}, 32'd1);
         if (n == 27) chk("hold_busy_e27", {31'd0, busy1}, 32'd1);
         if (n == 47) chk("hold_hex0_e47", {25'd0, hx1[0]}, 32'h78);
         if (n == 48) chk("hold_hex0_e48", {25'd0, hx1[0]}, 32'h00);
      end
      drive(1'b0, 20'd0);
      step();
      chk("hold_done_count", dn, 2);
      chk("hold_done_first", d_first, 26);
      chk("hold_done_gap", d_second - d_first, 27);
      chk("hold_idle_after", {31'd0, if1.score_ready}, 32'd1);

      // Scan order: 654321 written over 999999, one digit per edge from E21.
      send(20'd999999);
      chk_hex("pre_scan", all_nine, all_nine);
      drive(1'b1, 20'd654321);
      step();                       // E0
      drive(1'b0, 20'd0);
      for (int n = 1; n <= 26; n++) begin
         step();
         if (n >= 20) begin
            for (int k = 0; k < 6; k++) begin
               chk($sformatf("scan_e%0d_hex%0d", n, k), {25'd0, hx1[k]},
                   {25'd0, (k < n - 20) ? e654321[k*7 +: 7] : 7'h10});
            end
         end
      end
      chk("scan_done", {31'd0, done1}, 32'd1);
      step();
      chk_hex("scan_final", e654321, e654321);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
